// File: rtl/counter_down_timer.sv
// Loadable down-counting timer with one-shot or periodic reload.
// It pulses underflow for one cycle at terminal count and reports busy/done.
module counter_down_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // start is honoured only when neither load nor stop is asserted.
  logic start_ok;
  assign start_ok = start && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= CNT_ZERO;
      reload_q    <= CNT_ZERO;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok && (count_q != CNT_ZERO)) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (count_q == CNT_ZERO) begin
            // Unreachable under legal control; park in DONE without a pulse.
            state_d = DONE;
          end else if (count_q == CNT_ONE) begin
            underflow_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = CNT_ZERO;
              state_d = DONE;
            end
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        PAUSE: begin
          if (start_ok) state_d = RUN;
        end
        DONE: begin
          if (start_ok && (reload_q != CNT_ZERO)) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status flags are registered copies of the next-state decode.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign count     = count_q;
  assign underflow = underflow_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_down_timer.sv
// Directed bench for counter_down_timer (WIDTH=8) using an expected-output queue.
module tb_counter_down_timer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         underflow;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [W-1:0] count;
    logic         uf;
    logic         busy;
    logic         done;
  } obs_t;

  obs_t sb_q[$];
  int   n_assert;
  int   n_fail;

  counter_down_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .count      (count),
    .underflow  (underflow),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.count = count;
    o.uf    = underflow;
    o.busy  = busy;
    o.done  = done;
    return o;
  endfunction

  task automatic compare(input string tag, input obs_t got, input obs_t exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed count=%0d uf=%b busy=%b done=%b, expected count=%0d uf=%b busy=%b done=%b",
             tag, got.count, got.uf, got.busy, got.done, exp.count, exp.uf, exp.busy, exp.done);
    end
  endtask

  // Drive one cycle of controls, queue its expected result, then check it after the edge.
  task automatic step(input string tag, input logic ld, input logic [W-1:0] lv,
                      input logic st, input logic sp, input logic ar,
                      input logic [W-1:0] e_cnt, input logic e_uf,
                      input logic e_busy, input logic e_done);
    obs_t e;
    @(negedge clk);
    load = ld; load_value = lv; start = st; stop = sp; auto_reload = ar;
    e.count = e_cnt; e.uf = e_uf; e.busy = e_busy; e.done = e_done;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      compare(tag, sample(), sb_q.pop_front());
    end
  endtask

  obs_t zero_o;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    zero_o   = '0;
    rst_n = 1'b0; load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare("reset_init", sample(), zero_o);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot: 5 -> underflow exactly 5 cycles after start.
    step("os_load",  1, 8'd5, 0, 0, 0, 8'd5, 0, 0, 0);
    step("os_start", 0, 8'd0, 1, 0, 0, 8'd5, 0, 1, 0);
    for (int k = 4; k >= 1; k--)
      step("os_dec", 0, 8'd0, 0, 0, 0, W'(k), 0, 1, 0);
    step("os_term", 0, 8'd0, 0, 0, 0, 8'd0, 1, 0, 1);
    step("os_hold", 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);
    step("os_hold2", 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);
    // DONE + start relaunches from the reload value.
    step("done_restart", 0, 8'd0, 1, 0, 0, 8'd5, 0, 1, 0);
    step("done_rs_dec",  0, 8'd0, 0, 0, 0, 8'd4, 0, 1, 0);

    // Priority: load beats start; stop beats start in RUN.
    step("pri_ld_st",  1, 8'd7, 1, 0, 0, 8'd7, 0, 0, 0);
    step("pri_idle",   0, 8'd0, 0, 0, 0, 8'd7, 0, 0, 0);
    step("pri_start",  0, 8'd0, 1, 0, 0, 8'd7, 0, 1, 0);
    step("pri_sp_st",  0, 8'd0, 1, 1, 0, 8'd7, 0, 0, 0);

    // Pause/resume.
    step("pr_load",  1, 8'd10, 0, 0, 0, 8'd10, 0, 0, 0);
    step("pr_start", 0, 8'd0,  1, 0, 0, 8'd10, 0, 1, 0);
    for (int k = 9; k >= 6; k--)
      step("pr_dec", 0, 8'd0, 0, 0, 0, W'(k), 0, 1, 0);
    step("pr_stop", 0, 8'd0, 0, 1, 0, 8'd6, 0, 0, 0);
    step("pr_held", 0, 8'd0, 0, 0, 0, 8'd6, 0, 0, 0);
    step("pr_stop2", 0, 8'd0, 0, 1, 0, 8'd6, 0, 0, 0);
    step("pr_resume", 0, 8'd0, 1, 0, 0, 8'd6, 0, 1, 0);
    for (int k = 5; k >= 1; k--)
      step("pr_dec2", 0, 8'd0, 0, 0, 0, W'(k), 0, 1, 0);
    step("pr_term", 0, 8'd0, 0, 0, 0, 8'd0, 1, 0, 1);

    // Periodic 3: ten periods with no drift, then one-shot at next terminal.
    step("per_load",  1, 8'd3, 0, 0, 1, 8'd3, 0, 0, 0);
    step("per_start", 0, 8'd0, 1, 0, 1, 8'd3, 0, 1, 0);
    for (int p = 0; p < 10; p++) begin
      step("per_2",  0, 8'd0, 0, 0, 1, 8'd2, 0, 1, 0);
      step("per_1",  0, 8'd0, 0, 0, 1, 8'd1, 0, 1, 0);
      step("per_rl", 0, 8'd0, 0, 0, 1, 8'd3, 1, 1, 0);
    end
    step("per_ar0_2", 0, 8'd0, 0, 0, 0, 8'd2, 0, 1, 0);
    step("per_ar0_1", 0, 8'd0, 0, 0, 0, 8'd1, 0, 1, 0);
    step("per_ar0_t", 0, 8'd0, 0, 0, 0, 8'd0, 1, 0, 1);

    // Load at count==1 in RUN aborts without underflow.
    step("ab_load",  1, 8'd4, 0, 0, 0, 8'd4, 0, 0, 0);
    step("ab_start", 0, 8'd0, 1, 0, 0, 8'd4, 0, 1, 0);
    for (int k = 3; k >= 1; k--)
      step("ab_dec", 0, 8'd0, 0, 0, 0, W'(k), 0, 1, 0);
    step("ab_reload", 1, 8'd9, 0, 0, 0, 8'd9, 0, 0, 0);
    step("ab_idle",   0, 8'd0, 0, 0, 0, 8'd9, 0, 0, 0);

    // Zero load cannot start.
    step("z_load",  1, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);
    step("z_start", 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);
    step("z_idle",  0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);

    // N=1 periodic: underflow every cycle, count pinned at 1.
    step("n1_load",  1, 8'd1, 0, 0, 1, 8'd1, 0, 0, 0);
    step("n1_start", 0, 8'd0, 1, 0, 1, 8'd1, 0, 1, 0);
    for (int k = 0; k < 5; k++)
      step("n1_uf", 0, 8'd0, 0, 0, 1, 8'd1, 1, 1, 0);
    step("n1_end", 0, 8'd0, 0, 0, 0, 8'd0, 1, 0, 1);

    // All-ones one-shot: 255 cycles to underflow, no wrap afterwards.
    step("max_load",  1, 8'd255, 0, 0, 0, 8'd255, 0, 0, 0);
    step("max_start", 0, 8'd0,   1, 0, 0, 8'd255, 0, 1, 0);
    for (int k = 254; k >= 1; k--)
      step("max_dec", 0, 8'd0, 0, 0, 0, W'(k), 0, 1, 0);
    step("max_term", 0, 8'd0, 0, 0, 0, 8'd0, 1, 0, 1);
    step("max_nowrap", 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);

    // Asynchronous reset mid-run.
    step("rs_load",  1, 8'd20, 0, 0, 1, 8'd20, 0, 0, 0);
    step("rs_start", 0, 8'd0,  1, 0, 1, 8'd20, 0, 1, 0);
    step("rs_dec",   0, 8'd0,  0, 0, 1, 8'd19, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    compare("rst_async", sample(), zero_o);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      compare("rst_hold", sample(), zero_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // reload_reg was cleared, so a start from IDLE with count 0 is ignored.
    step("rs_after", 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
